// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS single-cycle datapath blocks:
// sequencer states and the PC reset/increment constants.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } seq_state_e;

  localparam logic [31:0] PC_INCR              = 32'd4;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping, so the
// harness can tell "very many" apart from "few".
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and next-PC selection for the single-cycle MIPS core,
// including halt/fault tracking and retired/taken performance counters.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          CNT_WIDTH    = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 zero,
  input  logic                 branch_eq,
  input  logic                 branch_ne,
  input  logic                 jump,
  input  logic                 jump_reg,
  input  logic                 halt,
  input  logic [31:0]          imm_ext,
  input  logic [25:0]          jump_index,
  input  logic [31:0]          reg_target,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  output logic                 branch_taken,
  output logic                 halted,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic [CNT_WIDTH-1:0] taken_count
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  seq_state_e  state_q;
  seq_state_e  state_d;
  logic        instrInc;
  logic        takenInc;
  logic [31:0] branchTarget;
  logic [31:0] jumpTarget;

  assign pc_plus4     = pc_q + PC_INCR;
  assign branch_taken = (branch_eq & zero) | (branch_ne & ~zero);
  assign branchTarget = pc_plus4 + {imm_ext[29:0], 2'b00};
  assign jumpTarget   = {pc_plus4[31:28], jump_index, 2'b00};

  // A misaligned JR target freezes the stage without retiring the instruction.
  always_comb begin
    pc_d     = pc_q;
    state_d  = state_q;
    instrInc = 1'b0;
    takenInc = 1'b0;
    if (enable && (state_q == ST_RUN)) begin
      instrInc = 1'b1;
      if (halt) begin
        state_d = ST_HALTED;
      end else if (jump_reg) begin
        if (reg_target[1:0] != 2'b00) begin
          state_d  = ST_FAULT;
          instrInc = 1'b0;
        end else begin
          pc_d     = reg_target;
          takenInc = 1'b1;
        end
      end else if (jump) begin
        pc_d     = jumpTarget;
        takenInc = 1'b1;
      end else if (branch_taken) begin
        pc_d     = branchTarget;
        takenInc = 1'b1;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  assign pc     = pc_q;
  assign halted = (state_q == ST_HALTED);
  assign fault  = (state_q == ST_FAULT);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_instr_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (instrInc),
    .count (instr_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_taken_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (takenInc),
    .count (taken_count)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer, with a narrow-counter
// instance to exercise counter saturation.
module tb_pc_sequencer;

  typedef struct {
    logic        rst;
    logic        en;
    logic        zero;
    logic        beq;
    logic        bne;
    logic        jmp;
    logic        jr;
    logic        hlt;
    logic [31:0] imm;
    logic [25:0] jidx;
    logic [31:0] rt;
    logic        expTaken;
    logic [31:0] expPc;
    logic        expHalted;
    logic        expFault;
    logic [31:0] expInstr;
    logic [31:0] expTakenCnt;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        zero = 1'b0;
  logic        branchEq = 1'b0;
  logic        branchNe = 1'b0;
  logic        jump = 1'b0;
  logic        jumpReg = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] immExt = '0;
  logic [25:0] jumpIndex = '0;
  logic [31:0] regTarget = '0;

  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        branchTaken;
  logic        halted;
  logic        fault;
  logic [31:0] instrCount;
  logic [31:0] takenCount;

  logic [31:0] pcN;
  logic [31:0] pcPlus4N;
  logic        branchTakenN;
  logic        haltedN;
  logic        faultN;
  logic [3:0]  instrCountN;
  logic [3:0]  takenCountN;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clock = ~clock;

  pc_sequencer #(.RESET_VECTOR(32'h0), .CNT_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .enable(enable), .zero(zero),
    .branch_eq(branchEq), .branch_ne(branchNe), .jump(jump),
    .jump_reg(jumpReg), .halt(halt), .imm_ext(immExt),
    .jump_index(jumpIndex), .reg_target(regTarget),
    .pc(pc), .pc_plus4(pcPlus4), .branch_taken(branchTaken),
    .halted(halted), .fault(fault),
    .instr_count(instrCount), .taken_count(takenCount)
  );

  pc_sequencer #(.RESET_VECTOR(32'h0), .CNT_WIDTH(4)) dutNarrow (
    .clock(clock), .reset(reset), .enable(enable), .zero(zero),
    .branch_eq(branchEq), .branch_ne(branchNe), .jump(jump),
    .jump_reg(jumpReg), .halt(halt), .imm_ext(immExt),
    .jump_index(jumpIndex), .reg_target(regTarget),
    .pc(pcN), .pc_plus4(pcPlus4N), .branch_taken(branchTakenN),
    .halted(haltedN), .fault(faultN),
    .instr_count(instrCountN), .taken_count(takenCountN)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one vector's inputs after the falling edge so they settle before the rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    reset     = v.rst;
    enable    = v.en;
    zero      = v.zero;
    branchEq  = v.beq;
    branchNe  = v.bne;
    jump      = v.jmp;
    jumpReg   = v.jr;
    halt      = v.hlt;
    immExt    = v.imm;
    jumpIndex = v.jidx;
    regTarget = v.rt;
  endtask

  task automatic runPlain(input logic rst, input logic en, input logic jmp, input logic [25:0] jidx);
    vec_t v;
    v = '{rst, en, 1'b0, 1'b0, 1'b0, jmp, 1'b0, 1'b0, 32'h0, jidx, 32'h0,
          1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    applyStimulus(v);
    @(posedge clock);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] prevPc;
    logic        prevValid;

    vecs.push_back('{1,0,0,0,0,0,0,0, 32'h0,        26'h0,  32'h0,         0, 32'h0000_0000, 0,0, 32'd0,  32'd0});
    vecs.push_back('{0,1,0,0,0,0,0,0, 32'h0,        26'h0,  32'h0,         0, 32'h0000_0004, 0,0, 32'd1,  32'd0});
    vecs.push_back('{0,1,0,0,0,0,0,0, 32'h0,        26'h0,  32'h0,         0, 32'h0000_0008, 0,0, 32'd2,  32'd0});
    vecs.push_back('{0,1,0,0,0,0,0,0, 32'h0,        26'h0,  32'h0,         0, 32'h0000_000C, 0,0, 32'd3,  32'd0});
    vecs.push_back('{0,1,0,0,0,0,0,0, 32'h0,        26'h0,  32'h0,         0, 32'h0000_0010, 0,0, 32'd4,  32'd0});
    vecs.push_back('{0,1,1,1,0,0,0,0, 32'hFFFF_FFFE,26'h0,  32'h0,         1, 32'h0000_000C, 0,0, 32'd5,  32'd1});
    vecs.push_back('{0,1,0,0,0,0,0,0, 32'h0,        26'h0,  32'h0,         0, 32'h0000_0010, 0,0, 32'd6,  32'd1});
    vecs.push_back('{0,1,0,1,0,0,0,0, 32'hFFFF_FFFE,26'h0,  32'h0,         0, 32'h0000_0014, 0,0, 32'd7,  32'd1});
    vecs.push_back('{0,1,0,0,1,0,0,0, 32'h3,        26'h0,  32'h0,         1, 32'h0000_0024, 0,0, 32'd8,  32'd2});
    vecs.push_back('{0,0,0,0,0,1,0,0, 32'h0,        26'h40, 32'h0,         0, 32'h0000_0024, 0,0, 32'd8,  32'd2});
    vecs.push_back('{0,0,0,0,1,0,0,0, 32'h0,        26'h0,  32'h0,         1, 32'h0000_0024, 0,0, 32'd8,  32'd2});
    vecs.push_back('{0,1,0,0,0,0,1,0, 32'h0,        26'h0,  32'h1000_0000, 0, 32'h1000_0000, 0,0, 32'd9,  32'd3});
    vecs.push_back('{0,1,0,0,1,1,0,0, 32'h100,      26'h40, 32'h0,         1, 32'h1000_0100, 0,0, 32'd10, 32'd4});
    vecs.push_back('{0,1,0,0,0,1,1,0, 32'h0,        26'h0,  32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0,0, 32'd11, 32'd5});
    vecs.push_back('{0,1,0,0,0,0,0,0, 32'h0,        26'h0,  32'h0,         0, 32'h0000_0000, 0,0, 32'd12, 32'd5});
    vecs.push_back('{0,1,0,0,0,1,0,0, 32'h0,        26'h8,  32'h0,         0, 32'h0000_0020, 0,0, 32'd13, 32'd6});
    vecs.push_back('{0,1,0,0,0,1,0,1, 32'h0,        26'h40, 32'h0,         0, 32'h0000_0020, 1,0, 32'd14, 32'd6});
    vecs.push_back('{0,1,0,0,0,0,0,0, 32'h0,        26'h0,  32'h0,         0, 32'h0000_0020, 1,0, 32'd14, 32'd6});
    vecs.push_back('{1,0,0,0,0,0,0,0, 32'h0,        26'h0,  32'h0,         0, 32'h0000_0000, 0,0, 32'd0,  32'd0});
    vecs.push_back('{0,1,0,0,0,0,0,0, 32'h0,        26'h0,  32'h0,         0, 32'h0000_0004, 0,0, 32'd1,  32'd0});
    vecs.push_back('{0,1,0,0,0,0,1,0, 32'h0,        26'h0,  32'h0000_0202, 0, 32'h0000_0004, 0,1, 32'd1,  32'd0});
    vecs.push_back('{0,1,0,0,0,1,0,0, 32'h0,        26'h40, 32'h0,         0, 32'h0000_0004, 0,1, 32'd1,  32'd0});
    vecs.push_back('{1,1,0,0,0,1,0,0, 32'h0,        26'h40, 32'h0,         0, 32'h0000_0000, 0,0, 32'd0,  32'd0});
    vecs.push_back('{0,1,0,0,0,0,0,0, 32'h0,        26'h0,  32'h0,         0, 32'h0000_0004, 0,0, 32'd1,  32'd0});

    prevPc    = '0;
    prevValid = 1'b0;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d branch_taken", i), {31'b0, branchTaken}, {31'b0, vecs[i].expTaken});
      if (prevValid) begin
        checkOutput($sformatf("v%0d pc_plus4", i), pcPlus4, prevPc + 32'd4);
      end
      @(posedge clock);
      #1;
      checkOutput($sformatf("v%0d pc", i), pc, vecs[i].expPc);
      checkOutput($sformatf("v%0d halted", i), {31'b0, halted}, {31'b0, vecs[i].expHalted});
      checkOutput($sformatf("v%0d fault", i), {31'b0, fault}, {31'b0, vecs[i].expFault});
      checkOutput($sformatf("v%0d instr_count", i), instrCount, vecs[i].expInstr);
      checkOutput($sformatf("v%0d taken_count", i), takenCount, vecs[i].expTakenCnt);
      prevPc    = vecs[i].expPc;
      prevValid = 1'b1;
    end

    // Jump-to-zero loop: every cycle retires and is taken, driving the 4-bit counters to saturation.
    runPlain(1'b1, 1'b0, 1'b0, 26'h0);
    for (int k = 0; k < 14; k++) runPlain(1'b0, 1'b1, 1'b1, 26'h0);
    checkOutput("narrow instr 14", {28'b0, instrCountN}, 32'hE);
    checkOutput("narrow taken 14", {28'b0, takenCountN}, 32'hE);
    runPlain(1'b0, 1'b1, 1'b1, 26'h0);
    checkOutput("narrow instr 15", {28'b0, instrCountN}, 32'hF);
    for (int k = 0; k < 5; k++) runPlain(1'b0, 1'b1, 1'b1, 26'h0);
    checkOutput("narrow instr sat", {28'b0, instrCountN}, 32'hF);
    checkOutput("narrow taken sat", {28'b0, takenCountN}, 32'hF);
    checkOutput("wide instr 20", instrCount, 32'd20);
    checkOutput("wide taken 20", takenCount, 32'd20);
    checkOutput("loop pc", pc, 32'h0);

    // Several stalled cycles with a pending jump must change nothing.
    runPlain(1'b0, 1'b1, 1'b0, 26'h0);
    checkOutput("pre-stall pc", pc, 32'h4);
    for (int k = 0; k < 4; k++) runPlain(1'b0, 1'b0, 1'b1, 26'h100);
    checkOutput("stall pc", pc, 32'h4);
    checkOutput("stall instr", instrCount, 32'd21);
    checkOutput("stall taken", takenCount, 32'd20);
    runPlain(1'b0, 1'b1, 1'b1, 26'h100);
    checkOutput("post-stall pc", pc, 32'h0000_0400);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
